servo_pwm_multi: RTL and testbench



---
 rtl/servo_pwm_multi_if.sv | 25 ++
 rtl/servo_pwm_multi.sv | 129 ++++++++++++
 tb/tb_servo_pwm_multi.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_multi_if.sv
// Command port for servo_pwm_multi: valid/ready handshake carrying a channel index and a
// requested pulse width. The controller drives through master; the PWM block is the slave.
interface servo_pwm_multi_if #(
  parameter int unsigned CH_W    = 2,
  parameter int unsigned W_WIDTH = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [CH_W-1:0]    cmd_ch;
  logic [W_WIDTH-1:0] cmd_width;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_width,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_width,
    output cmd_ready
  );
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator. One shared period counter; each channel compares it
// against its current width. Commanded targets are clamped to MAX_WIDTH and approached at
// the period boundary only, so no pulse is ever cut short or stretched mid-period.
// Optional feature macro SERVO_PWM_SLEW_EN: when defined, cur moves toward target by at
// most STEP per period; when undefined, cur jumps straight to target at the next boundary.
module servo_pwm_multi #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CONF_PERIODO = 1250,
  parameter int unsigned W_WIDTH      = 16,
  parameter int unsigned MAX_WIDTH    = 125,
  parameter int unsigned INIT_WIDTH   = 50,
  parameter int unsigned STEP         = 5
) (
  input  logic                clock,
  input  logic                reset,
  servo_pwm_multi_if.slave    cmd,
  output logic [N_CH-1:0]     pwm,
  output logic [N_CH-1:0]     busy,
  output logic                period_tick
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W = (CONF_PERIODO > 1) ? $clog2(CONF_PERIODO) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CONF_PERIODO - 1);
  localparam logic [W_WIDTH-1:0] W_MAX     = W_WIDTH'(MAX_WIDTH);
  localparam logic [W_WIDTH-1:0] W_INIT    = W_WIDTH'(INIT_WIDTH);

  if (N_CH < 1 || N_CH > 16 || STEP < 1 || CONF_PERIODO < 1) begin : g_bad_param
    $error("servo_pwm_multi: N_CH must be 1..16, STEP and CONF_PERIODO at least 1");
  end

  logic [CNT_W-1:0]   count_q, count_d;
  logic [W_WIDTH-1:0] cur_q    [N_CH];
  logic [W_WIDTH-1:0] cur_d    [N_CH];
  logic [W_WIDTH-1:0] target_q [N_CH];
  logic [W_WIDTH-1:0] target_d [N_CH];
  logic [N_CH-1:0]    pwm_q, pwm_d;
  logic [N_CH-1:0]    busy_q, busy_d;
  logic               tick_q, tick_d;

  logic               at_wrap;
  logic               accept;
  logic [W_WIDTH-1:0] width_clamped;

  // The last count of a period is the update cycle; commands are held off during it.
  assign at_wrap       = (count_q == CNT_LAST);
  assign cmd.cmd_ready = ~at_wrap;
  assign accept        = cmd.cmd_valid & ~at_wrap;
  assign width_clamped = (cmd.cmd_width > W_MAX) ? W_MAX : cmd.cmd_width;

  // Period counter, wrap pulse, per-channel compare and busy flags.
  always_comb begin
    count_d = at_wrap ? '0 : count_q + 1'b1;
    tick_d  = at_wrap;
    pwm_d   = '0;
    busy_d  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pwm_d[i]  = (32'(count_q) < 32'(cur_q[i]));
      busy_d[i] = (cur_q[i] != target_q[i]);
    end
  end

  // Target capture; an out-of-range channel index matches no entry and is dropped.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      target_d[i] = target_q[i];
      if (accept && (cmd.cmd_ch == CH_W'(i))) begin
        target_d[i] = width_clamped;
      end
    end
  end

`ifdef SERVO_PWM_SLEW_EN
  localparam logic signed [W_WIDTH:0] STEP_S = (W_WIDTH + 1)'(STEP);
  logic signed [W_WIDTH:0] diff [N_CH];

  // Slew-limited step toward target at the period boundary.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      diff[i]  = $signed({1'b0, target_q[i]}) - $signed({1'b0, cur_q[i]});
      cur_d[i] = cur_q[i];
      if (at_wrap) begin
        if (diff[i] > STEP_S) begin
          cur_d[i] = cur_q[i] + W_WIDTH'(STEP);
        end else if (diff[i] < -STEP_S) begin
          cur_d[i] = cur_q[i] - W_WIDTH'(STEP);
        end else begin
          cur_d[i] = target_q[i];
        end
      end
    end
  end
`else
  // Unlimited: adopt the target outright at the period boundary.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      cur_d[i] = at_wrap ? target_q[i] : cur_q[i];
    end
  end
`endif

  // State registers; reset forces pwm low immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      pwm_q   <= '0;
      busy_q  <= '0;
      tick_q  <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cur_q[i]    <= W_INIT;
        target_q[i] <= W_INIT;
      end
    end else begin
      count_q <= count_d;
      pwm_q   <= pwm_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cur_q[i]    <= cur_d[i];
        target_q[i] <= target_d[i];
      end
    end
  end

  assign pwm         = pwm_q;
  assign busy        = busy_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi. Six channels so that index 7 is representable and
// out of range. Pulse widths are measured by counting high samples over one full period
// between period_tick pulses. Expected widths follow the build's SERVO_PWM_SLEW_EN setting.
module tb_servo_pwm_multi;

  localparam int unsigned N_CH    = 6;
  localparam int unsigned CH_W    = 3;
  localparam int unsigned PERIOD  = 1250;
  localparam int unsigned W_WIDTH = 16;

`ifdef SERVO_PWM_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic            clock;
  logic            reset;
  logic [N_CH-1:0] pwm;
  logic [N_CH-1:0] busy;
  logic            period_tick;

  servo_pwm_multi_if #(.CH_W(CH_W), .W_WIDTH(W_WIDTH)) cmd_if ();

  servo_pwm_multi #(
    .N_CH         (N_CH),
    .CONF_PERIODO (PERIOD),
    .W_WIDTH      (W_WIDTH),
    .MAX_WIDTH    (125),
    .INIT_WIDTH   (50),
    .STEP         (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd         (cmd_if.slave),
    .pwm         (pwm),
    .busy        (busy),
    .period_tick (period_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int exp_w [N_CH];
  logic [N_CH-1:0] exp_busy;
  int wc;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic set_all(input int w);
    for (int i = 0; i < N_CH; i++) exp_w[i] = w;
  endtask

  // Advance to a negedge where period_tick is high (the current one counts).
  task automatic sync_tick();
    int n;
    n = 0;
    while (!period_tick && n < PERIOD + 50) begin
      @(negedge clock);
      n++;
    end
    if (!period_tick) check("tick_timeout", 0, 1);
  endtask

  // Measure the next full period and compare widths, mid-period busy and tick spacing.
  task automatic check_period(input string tag);
    int hi [N_CH];
    int ticks;
    logic [N_CH-1:0] busy_mid;
    sync_tick();
    for (int i = 0; i < N_CH; i++) hi[i] = 0;
    ticks    = 0;
    busy_mid = '0;
    for (int k = 1; k <= int'(PERIOD); k++) begin
      @(negedge clock);
      for (int i = 0; i < N_CH; i++) hi[i] += int'(pwm[i]);
      if (period_tick) ticks++;
      if (k == 625) busy_mid = busy;
    end
    for (int i = 0; i < N_CH; i++) begin
      check($sformatf("%s_w%0d", tag, i), hi[i], exp_w[i]);
    end
    check($sformatf("%s_busy", tag), int'(busy_mid), int'(exp_busy));
    check($sformatf("%s_ticks", tag), ticks, 1);
    check($sformatf("%s_tick_end", tag), int'(period_tick), 1);
  endtask

  // Present a command at the current negedge and hold it until accepted.
  task automatic send(input int ch, input int width, output int waits);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = CH_W'(ch);
    cmd_if.cmd_width = W_WIDTH'(width);
    waits = 0;
    while (!cmd_if.cmd_ready && waits < 8) begin
      @(negedge clock);
      waits++;
    end
    if (!cmd_if.cmd_ready) check("send_timeout", 0, 1);
    @(negedge clock);
  endtask

  task automatic idle();
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch    = '0;
    cmd_if.cmd_width = '0;
    repeat (3) @(negedge clock);
    check("rst_pwm", int'(pwm), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tick", int'(period_tick), 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", int'(cmd_if.cmd_ready), 1);

    // Idle: every channel at the reset width.
    set_all(50);
    exp_busy = '0;
    check_period("idle0");
    check_period("idle1");

    // Small move on ch0, out-of-range ch7 dropped (would alias nothing).
    send(0, 52, wc);
    send(7, 10, wc);
    idle();
    set_all(50);
    exp_w[0] = 52;
    check_period("drop");

    // Ramps: ch0 to 100, ch1 clamped to 125, ch3 overwritten 70 -> 90 back-to-back.
    send(0, 100, wc);
    send(1, 200, wc);
    send(3, 70, wc);
    send(3, 90, wc);
    idle();
    for (int j = 1; j <= 15; j++) begin
      set_all(50);
      exp_busy = '0;
      if (SLEW) begin
        exp_w[0]    = min2(52 + 5 * j, 100);
        exp_w[1]    = min2(50 + 5 * j, 125);
        exp_w[3]    = min2(50 + 5 * j, 90);
        exp_busy[0] = (52 + 5 * j < 100);
        exp_busy[1] = (50 + 5 * j < 125);
        exp_busy[3] = (50 + 5 * j < 90);
      end else begin
        exp_w[0] = 100;
        exp_w[1] = 125;
        exp_w[3] = 90;
      end
      check_period($sformatf("ramp%0d", j));
    end

    // Valid held across the update cycle: refused there, taken the cycle after.
    repeat (PERIOD - 1) @(negedge clock);
    check("ready_low_at_wrap", int'(cmd_if.cmd_ready), 0);
    send(2, 60, wc);
    idle();
    check("hold_wait", wc, 1);
    set_all(50);
    exp_w[0] = 100;
    exp_w[1] = 125;
    exp_w[3] = 90;
    exp_w[2] = SLEW ? 55 : 60;
    exp_busy = '0;
    exp_busy[2] = SLEW;
    check_period("hold1");
    exp_w[2] = 60;
    exp_busy = '0;
    check_period("hold2");

    // Reset in the middle of a move: pwm drops at once, everything back to 50.
    send(0, 125, wc);
    idle();
    sync_tick();
    repeat (10) @(negedge clock);
    check("pre_rst_pwm0", int'(pwm[0]), 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_pwm", int'(pwm), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_tick", int'(period_tick), 0);
    @(negedge clock);
    reset = 1'b0;
    set_all(50);
    exp_busy = '0;
    check_period("post_rst");

    send(0, 100, wc);
    idle();
    set_all(50);
    exp_w[0] = SLEW ? 55 : 100;
    exp_busy = '0;
    exp_busy[0] = SLEW;
    check_period("post_rst_cmd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
